alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit zx/nx/zy/ny/f/no combinational ALU.
- Adds configurable width, a valid/ready handshake on input and output, and an internal accumulator usable as the y operand.
- Adds carry and signed-overflow flags.
- Sits between the instruction/operand sequencer and the register-file write-back.

Parameters:
- WIDTH, 8: data width of x, y, o and the accumulator (≥2).
- ACC_EN, 1: 1 = accumulator present; 0 = use_acc/acc_wr are ignored and acc reads as 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid & in_ready
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- ctrl  in  6  {zx,nx,zy,ny,f,no}; bit5 = zx, bit0 = no
- use_acc  in  1  substitute accumulator for y
- acc_wr  in  1  write this op's result into accumulator
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- o  out  WIDTH  result
- zr  out  1  o == 0
- ng  out  1  o[WIDTH-1]
- cy  out  1  carry out of adder
- ov  out  1  signed overflow of adder
- acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (rst_n=0 at posedge): s1_valid=0, out_valid=0, o=0, zr=0, ng=0, cy=0, ov=0, acc=0. In-flight ops are discarded. in_ready is 1 in the first cycle after reset.
- Stage 1 (input register): on accept, captures x, y, ctrl, use_acc, acc_wr.
- Stage 2 (output register): result computed combinationally from the stage-1 contents and registered on advance.
- Latency: 2 cycles from accept to out_valid with no stall.
- Throughput: 1 op/cycle with no stall.
- Advance rules:
  - out_adv = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | out_adv.
  - out_valid is cleared on consume only when no out_adv occurs in the same cycle.
- Output stability: while out_valid & !out_ready, o/zr/ng/cy/ov hold. Stage 1 holds, in_ready=0.
- Operand y' = (ACC_EN & use_acc) ? acc : y. The accumulator is read when the op sits in stage 1.
- Arithmetic, in order, all WIDTH bits:
  - xa = zx ? 0 : x; xb = nx ? ~xa : xa.
  - ya = zy ? 0 : y'; yb = ny ? ~ya : ya.
  - f=1: {c, s} = xb + yb (WIDTH+1 bits). cy = c. ov = (xb[MSB]==yb[MSB]) & (s[MSB]!=xb[MSB]).
  - f=0: s = xb & yb; cy = 0; ov = 0.
  - o = no ? ~s : s. cy/ov always describe the pre-no adder.
  - zr and ng are registered with o.
- Accumulator: written with o on the same edge the op is loaded into the output register (out_adv & acc_wr & ACC_EN). A dependent op immediately following in stage 1 reads the updated value, so there is no hazard and back-to-back accumulation is 1/cycle.
- Stall with acc dependency: the accumulator is not written until out_adv, so ops in stage 1 always see the architecturally correct value.
- Simultaneous accept and output consume in the same cycle: both occur; no bubble.
- Reset mid-operation: the accumulator clears, and any result not yet consumed is lost.

Decomposition:
- Package alu_pkg:
  - ctrl bit index constants: CTRL_ZX=5 … CTRL_NO=0.
  - Named 6-bit opcode constants: OP_ZERO=101010, OP_ONE=111111, OP_NEG1=111010, OP_X=001100, OP_Y=110000, OP_NOTX=001101, OP_NOTY=110001, OP_NEGX=001111, OP_NEGY=110011, OP_XP1=011111, OP_YP1=110111, OP_XM1=001110, OP_YM1=110010, OP_ADD=000010, OP_SUB=010011, OP_RSUB=000111, OP_AND=000000, OP_OR=010101.
- Sub-module alu_core: purely combinational, parametrised by WIDTH. Inputs xb/yb path and ctrl; outputs o, cy, ov. alu_pipe instantiates it once between the stages.

Test Plan:
- WIDTH=8, OP_ADD, x=0x76, y=0x2A, out_ready=1 -> 2 cycles later o=0xA0, ng=1, zr=0, cy=0, ov=1.
- OP_ADD, x=0xFF, y=0xCF -> o=0xCE, cy=1, ov=0, ng=1. Then OP_SUB, x=0x03, y=0x03 -> o=0x00, zr=1.
- After reset acc=0: three back-to-back accepts of OP_ADD, x=0x05, use_acc=1, acc_wr=1 -> o=0x05, 0x0A, 0x0F on consecutive cycles; acc=0x0F.
- Backpressure: out_ready=0 while streaming 4 ops (x=1..4, OP_X) -> 2 accepted, then in_ready=0, o holds 0x01. Release out_ready -> outputs 1, 2, 3, 4 in order, none lost or duplicated.
- All 18 opcodes with x=0xE7, y=0xD5 -> each o/zr/ng matches the alu_pkg reference model, and cy/ov match the pre-no adder.
- rst_n=0 for one cycle with 2 ops in flight and acc=0x0F -> next cycle out_valid=0, acc=0, in_ready=1, and no stale result is ever emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined zx/nx/zy/ny/f/no ALU: control bit
// positions, a decoded control view and the named opcodes the sequencer emits.
package alu_pkg;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

    localparam logic [5:0] OP_ZERO = 6'b101010;
    localparam logic [5:0] OP_ONE  = 6'b111111;
    localparam logic [5:0] OP_NEG1 = 6'b111010;
    localparam logic [5:0] OP_X    = 6'b001100;
    localparam logic [5:0] OP_Y    = 6'b110000;
    localparam logic [5:0] OP_NOTX = 6'b001101;
    localparam logic [5:0] OP_NOTY = 6'b110001;
    localparam logic [5:0] OP_NEGX = 6'b001111;
    localparam logic [5:0] OP_NEGY = 6'b110011;
    localparam logic [5:0] OP_XP1  = 6'b011111;
    localparam logic [5:0] OP_YP1  = 6'b110111;
    localparam logic [5:0] OP_XM1  = 6'b001110;
    localparam logic [5:0] OP_YM1  = 6'b110010;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_RSUB = 6'b000111;
    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand zero/invert, add-or-and, optional output
// invert. Carry and overflow always describe the adder before the final invert.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic [WIDTH-1:0] o,
    output logic             cy,
    output logic             ov
);

    ctrl_t            c;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] yb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s;

    assign c = ctrl_t'(ctrl);

    always_comb begin
        xa  = c.zx ? '0 : x;
        xb  = c.nx ? ~xa : xa;
        ya  = c.zy ? '0 : y;
        yb  = c.ny ? ~ya : ya;
        sum = {1'b0, xb} + {1'b0, yb};
        cy  = 1'b0;
        ov  = 1'b0;
        if (c.f) begin
            s  = sum[WIDTH-1:0];
            cy = sum[WIDTH];
            ov = (xb[WIDTH-1] == yb[WIDTH-1]) && (s[WIDTH-1] != xb[WIDTH-1]);
        end else begin
            s = xb & yb;
        end
        o = c.no ? ~s : s;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with an optional accumulator that can replace y.
// Stage 1 holds the accepted op; the result is registered into stage 2.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic             use_acc,
    input  logic             acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov,
    output logic [WIDTH-1:0] acc
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [5:0]       s1_ctrl;
    logic             s1_use_acc;
    logic             s1_acc_wr;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH-1:0] core_o;
    logic             core_cy;
    logic             core_ov;

    logic             out_adv;
    logic             accept;

    assign out_adv  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || out_adv;
    assign accept   = in_valid && in_ready;

    // The op in stage 1 reads the accumulator live, so a write made by the op
    // ahead of it on the previous edge is already visible: no forwarding needed.
    assign y_eff = ((ACC_EN != 0) && s1_use_acc) ? acc_q : s1_y;
    assign acc   = acc_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x    (s1_x),
        .y    (y_eff),
        .ctrl (s1_ctrl),
        .o    (core_o),
        .cy   (core_cy),
        .ov   (core_ov)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_ctrl    <= '0;
            s1_use_acc <= 1'b0;
            s1_acc_wr  <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_x       <= x;
            s1_y       <= y;
            s1_ctrl    <= ctrl;
            s1_use_acc <= use_acc;
            s1_acc_wr  <= acc_wr;
        end else if (out_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            cy        <= 1'b0;
            ov        <= 1'b0;
        end else if (out_adv) begin
            out_valid <= 1'b1;
            o         <= core_o;
            zr        <= (core_o == '0);
            ng        <= core_o[WIDTH-1];
            cy        <= core_cy;
            ov        <= core_ov;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if ((ACC_EN != 0) && out_adv && s1_acc_wr) begin
            acc_q <= core_o;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a driver pushes model results on accept and a
// monitor pops and compares on every consumed output.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [5:0]   ctrl = '0;
    logic         use_acc = 1'b0;
    logic         acc_wr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] o;
    logic         zr, ng, cy, ov;
    logic [W-1:0] acc;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .ACC_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .use_acc(use_acc), .acc_wr(acc_wr),
        .out_valid(out_valid), .out_ready(out_ready), .o(o),
        .zr(zr), .ng(ng), .cy(cy), .ov(ov), .acc(acc)
    );

    typedef struct {
        logic [11:0] res;   // {o, zr, ng, cy, ov}
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic [7:0]  m_acc = '0;

    logic [5:0] ops[18] = '{OP_ZERO, OP_ONE, OP_NEG1, OP_X, OP_Y, OP_NOTX,
                            OP_NOTY, OP_NEGX, OP_NEGY, OP_XP1, OP_YP1, OP_XM1,
                            OP_YM1, OP_ADD, OP_SUB, OP_RSUB, OP_AND, OP_OR};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [11:0] model(input int xi, input int yi, input logic [5:0] c);
        int xv, yv, s, sx, sy, ssum, ov_i, cy_i, ov_r, res;
        xv = c[5] ? 0 : xi;
        if (c[4]) xv = 255 - xv;
        yv = c[3] ? 0 : yi;
        if (c[2]) yv = 255 - yv;
        cy_i = 0;
        ov_r = 0;
        if (c[1]) begin
            s    = xv + yv;
            cy_i = (s > 255) ? 1 : 0;
            s    = s % 256;
            sx   = (xv > 127) ? xv - 256 : xv;
            sy   = (yv > 127) ? yv - 256 : yv;
            ssum = sx + sy;
            ov_r = (ssum > 127 || ssum < -128) ? 1 : 0;
        end else begin
            s = xv & yv;
        end
        res  = c[0] ? 255 - s : s;
        ov_i = ov_r;
        return {res[7:0], (res == 0), (res > 127), cy_i[0], ov_i[0]};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        bit          have_prev;
        logic [11:0] prev;
        exp_t        e;
        have_prev = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                have_prev = 0;
            end else begin
                if (have_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'({o, zr, ng, cy, ov}), 32'(prev));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_output: got o=%0h required no output", o);
                    end else begin
                        e = sb.pop_front();
                        check("result", 32'({o, zr, ng, cy, ov}), 32'(e.res));
                        if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                    end
                end
                have_prev = out_valid && !out_ready;
                prev = {o, zr, ng, cy, ov};
            end
        end
    end

    task automatic issue(input logic [7:0] xi, input logic [7:0] yi, input logic [5:0] c,
                         input logic ua, input logic aw, input bit fixed,
                         input logic [11:0] fres, input bit lat);
        int   waited;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        x = xi; y = yi; ctrl = c; use_acc = ua; acc_wr = aw;
        waited = 0;
        forever begin
            #3;
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.res = fixed ? fres : model(int'(xi), ua ? int'(m_acc) : int'(yi), c);
        if (aw) m_acc = e.res[11:4];
        e.cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        n_acc++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain", 32'(sb.size() != 0 || out_valid), 32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'({o, zr, ng, cy, ov}), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        rdy_mode = 0;
        issue(8'h76, 8'h2A, OP_ADD, 0, 0, 1, {8'hA0, 1'b0, 1'b1, 1'b0, 1'b1}, 1);
        drain();
        issue(8'hFF, 8'hCF, OP_ADD, 0, 0, 1, {8'hCE, 1'b0, 1'b1, 1'b1, 1'b0}, 1);
        issue(8'h03, 8'h03, OP_SUB, 0, 0, 1, {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}, 0);
        drain();

        issue(8'h05, 8'h00, OP_ADD, 1, 1, 1, {8'h05, 4'b0000}, 1);
        issue(8'h05, 8'h00, OP_ADD, 1, 1, 1, {8'h0A, 4'b0000}, 1);
        issue(8'h05, 8'h00, OP_ADD, 1, 1, 1, {8'h0F, 4'b0000}, 1);
        drain();
        check("acc_after_accum", 32'(acc), 32'h0F);

        rdy_mode = 2;
        base = n_acc;
        fork
            begin
                for (int i = 1; i <= 4; i++) issue(8'(i), 8'h00, OP_X, 0, 0, 0, '0, 0);
            end
        join_none
        repeat (6) @(negedge clk);
        #3;
        check("bp_accepted", 32'(n_acc - base), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_o_hold", 32'(o), 32'h01);
        rdy_mode = 0;
        wait fork;
        drain();
        check("bp_total", 32'(n_acc - base), 32'd4);

        rdy_mode = 1;
        for (int i = 0; i < 18; i++) issue(8'hE7, 8'hD5, ops[i], 0, 0, 0, '0, 0);
        drain();

        check("acc_before_reset", 32'(acc), 32'h0F);
        rdy_mode = 2;
        issue(8'h11, 8'h22, OP_ADD, 0, 0, 0, '0, 0);
        issue(8'h33, 8'h44, OP_OR, 0, 0, 0, '0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        rdy_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        issue(8'h03, 8'h00, OP_ADD, 1, 1, 0, '0, 1);
        issue(8'h03, 8'h00, OP_ADD, 1, 1, 0, '0, 1);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(8'($urandom), 8'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 0, '0, 0);
        end
        drain();
        check("acc_final", 32'(acc), 32'(m_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
